// File: rtl/vc_input_buffer_pkg.sv
// Shared definitions for the virtual-channel input buffer: flit type codes,
// one-hot output port codes, default widths and enable constants.
package vc_input_buffer_pkg;

  localparam int DATAW_DEF = 31;
  localparam int VCHW_DEF  = 0;
  localparam int PORTW_DEF = 4;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  localparam logic [4:0] PORT_N     = 5'b00001;
  localparam logic [4:0] PORT_E     = 5'b00010;
  localparam logic [4:0] PORT_S     = 5'b00100;
  localparam logic [4:0] PORT_W     = 5'b01000;
  localparam logic [4:0] PORT_LOCAL = 5'b10000;

  localparam logic Enable  = 1'b1;
  localparam logic Enable_ = 1'b0;

  // A flit opens a packet if it is a head or a single-flit packet
  function automatic logic starts_packet(input logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  function automatic logic ends_packet(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Parametrised synchronous FIFO with a fall-through read port and a peek at
// the tag bits of the entry behind the head.
module vc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [TAGW-1:0]          next_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_nxt;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full FIFO still accepts a write when an entry leaves in the same cycle
  assign do_push  = push & (~full | do_pop);
  assign rptr_nxt = rptr + AW'(1);
  assign rdata    = mem[rptr];
  assign next_tag = mem[rptr_nxt][W-1:W-TAGW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr_nxt;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-VC router input stage: buffers flits, computes the XY output port for
// each packet and forwards flits downstream on grant, returning credits.
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int VCHW  = VCHW_DEF,
  parameter int PORTW = PORTW_DEF,
  parameter int DEPTH = 4,
  parameter int CW    = 2,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int VC_ID = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid,
  input  logic [DATAW:0]   idata,
  input  logic             gnt,
  output logic             ovalid,
  output logic [DATAW:0]   odata,
  output logic [VCHW:0]    ovch,
  output logic             req,
  output logic [PORTW:0]   port,
  output logic             credit,
  output logic             err
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MYX = CW'(MY_X);
  localparam logic [CW-1:0] MYY = CW'(MY_Y);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROUTE  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]      state;
  logic [1:0]      nstate;
  logic [DATAW:0]  head_flit;
  logic [1:0]      next_tag;
  logic            full;
  logic            empty;
  logic [CNTW-1:0] count;
  logic            pop;
  logic            pop_tail;
  logic            fwd;
  logic            stray;
  logic            drop;
  logic            count_gt1;
  logic            post_valid;
  logic [1:0]      post_type;
  logic [1:0]      head_type;
  logic [1:0]      in_type;
  logic [CW-1:0]   dst_x;
  logic [CW-1:0]   dst_y;

  vc_fifo #(.W(DATAW+1), .DEPTH(DEPTH), .TAGW(2)) u_fifo (
    .clk      (clk),
    .rst      (rst_),
    .push     (ivalid),
    .pop      (pop),
    .wdata    (idata),
    .rdata    (head_flit),
    .next_tag (next_tag),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // X first, then Y, else deliver locally
  function automatic logic [PORTW:0] route(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
    if (dx > MYX)      return (PORTW+1)'(PORT_E);
    else if (dx < MYX) return (PORTW+1)'(PORT_W);
    else if (dy > MYY) return (PORTW+1)'(PORT_N);
    else if (dy < MYY) return (PORTW+1)'(PORT_S);
    else               return (PORTW+1)'(PORT_LOCAL);
  endfunction

  assign head_type = head_flit[DATAW:DATAW-1];
  assign in_type   = idata[DATAW:DATAW-1];
  assign dst_x     = head_flit[2*CW-1:CW];
  assign dst_y     = head_flit[CW-1:0];
  assign ovch      = (VCHW+1)'(VC_ID);
  assign req       = (state == S_ACTIVE) & ~empty;
  assign count_gt1 = (count > CNTW'(1));
  assign fwd       = pop & (state == S_ACTIVE);
  assign pop_tail  = fwd & ends_packet(head_type);
  assign stray     = pop & (state == S_IDLE);
  assign drop      = ivalid & full & ~pop;

  // Type of the flit sitting at the FIFO head after this edge; lets a queued
  // or arriving head enter ROUTE without an extra idle cycle
  always_comb begin
    post_valid = 1'b0;
    post_type  = FLIT_BODY;
    if (pop) begin
      post_valid = count_gt1 | ivalid;
      post_type  = count_gt1 ? next_tag : in_type;
    end else begin
      post_valid = ~empty | ivalid;
      post_type  = ~empty ? head_type : in_type;
    end
  end

  always_comb begin
    pop    = 1'b0;
    nstate = state;
    case (state)
      S_IDLE: begin
        pop = ~empty & ~starts_packet(head_type);
        if (post_valid && starts_packet(post_type)) nstate = S_ROUTE;
      end
      S_ROUTE: nstate = S_ACTIVE;
      S_ACTIVE: begin
        pop = gnt & req;
        if (pop_tail)
          nstate = (post_valid && starts_packet(post_type)) ? S_ROUTE : S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state  <= S_IDLE;
      port   <= '0;
      ovalid <= Enable_;
      odata  <= '0;
      credit <= Enable_;
      err    <= Enable_;
    end else begin
      state <= nstate;
      if (state == S_ROUTE) port <= route(dst_x, dst_y);
      else if (pop_tail)    port <= '0;
      ovalid <= fwd;
      odata  <= fwd ? head_flit : '0;
      credit <= pop;
      if (drop || stray) err <= Enable;
    end
  end

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Per-virtual-channel input stage of a router input port.
- Buffers incoming flits in a small FIFO and performs XY route computation on each head flit.
- Holds the computed output port for the whole packet and presents request/port/data to the downstream VC multiplexer.
- Pops flits on downstream grant and returns one credit per popped flit to the upstream router.

Parameters:
- DATAW, 31, flit MSB index (flit is DATAW+1 bits).
- VCHW, 0, VC id MSB index.
- PORTW, 4, port vector MSB index (one-hot, 5 ports).
- DEPTH, 4, FIFO entries (power of two, >=2).
- CW, 2, coordinate width per axis.
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.
- VC_ID, 0, value driven on ovch.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_  in  1  reset, asynchronous, active-high.
- ivalid  in  1  flit present on idata this cycle.
- idata  in  DATAW+1  incoming flit.
- gnt  in  1  downstream grant for this VC.
- ovalid  out  1  registered: flit valid on odata.
- odata  out  DATAW+1  registered forwarded flit.
- ovch  out  VCHW+1  constant VC_ID.
- req  out  1  request to downstream arbiter.
- port  out  PORTW+1  one-hot requested output port.
- credit  out  1  one-cycle pulse per popped flit.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_=1): FIFO empty, state IDLE, ovalid=0, odata=0, req=0, port=0, credit=0, err=0. ovch=VC_ID always.
- Flit type field = idata[DATAW:DATAW-1]: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).
- Head destination fields: dst_x = idata[2*CW-1:CW], dst_y = idata[CW-1:0].
- FIFO:
  - Push when ivalid. Pop when gnt & req & !empty.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push while full without a pop: flit dropped, err set.
  - Occupancy counter is clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Routing (XY, one-hot):
  - Port bits: bit0 N (dst_y>MY_Y), bit1 E (dst_x>MY_X), bit2 S (dst_y<MY_Y), bit3 W (dst_x<MY_X), bit4 local.
  - X resolved first: E/W if dst_x differs, else N/S if dst_y differs, else local.
- FSM:
  - IDLE: FIFO head is a head/single flit -> ROUTE.
  - IDLE: FIFO head is a body/tail flit -> pop it silently (credit pulses, no ovalid), set err, stay IDLE.
  - ROUTE (1 cycle): register port from head flit -> ACTIVE.
  - ACTIVE: req=1 while !empty; port held constant.
  - ACTIVE: popping a tail/single flit -> IDLE, and req/port clear next cycle.
  - ACTIVE: FIFO empty mid-packet -> req=0, port held, stay ACTIVE.
- Output timing:
  - On a pop cycle t, ovalid=1 and odata=popped flit at t+1, and credit=1 at t+1. Otherwise ovalid=0, odata=0, credit=0.
  - Latency from ivalid into an empty buffer to first req: 2 cycles (cycle t push, t+1 ROUTE, req high at t+2).
  - A head flit already queued behind a tail reaches ROUTE the cycle after the tail pops; there are no bubbles beyond the ROUTE cycle.
- gnt while req=0 is ignored.
- Reset asserted mid-packet: all state is cleared immediately, and partially buffered packets are discarded.

Decomposition:
- Shared defines file holds:
  - flit type codes (HEAD, BODY, TAIL, SINGLE);
  - one-hot port codes (N, E, S, W, LOCAL);
  - DATAW/VCHW/PORTW defaults;
  - Enable/Enable_ constants.
- One natural sub-module: vc_fifo, a parametrised synchronous FIFO with push/pop/full/empty/count and async active-high reset.
- Route computation and the FSM stay in vc_input_buffer.

Test Plan:
- Reset: hold rst_=1 for 3 cycles with random ivalid -> all outputs 0, ovch=VC_ID. Assert rst_ asynchronously mid-cycle -> outputs 0 immediately.
- Single flit, MY=(1,1), dst=(3,1), gnt tied 1:
  - req=1 and port=5'b00010 two cycles after push.
  - ovalid=1 with the same flit one cycle later, credit pulses once.
  - req=0 afterwards.
- 4-flit packet head(dst 1,0)/body/body/tail at MY=(1,1), gnt=1 from cycle 2:
  - port=5'b00100 for all four flits.
  - Four consecutive ovalid, four credits, return to IDLE.
- Backpressure and overflow, DEPTH=4, gnt=0:
  - Push 5 flits: first 4 stored, 5th dropped, err=1.
  - Raise gnt: exactly 4 flits out, in order.
- Simultaneous push/pop while full: FIFO stays at count 4, no err, data order preserved.
- Stray body flit at IDLE: popped with credit, no ovalid, err=1. A following head at dst=(1,1) yields port=5'b10000.
